// File: rtl/mem_dma_copy.sv
// mem_dma_copy: byte-serial block copier that acts as the bus initiator of a
// 64K x 8 synchronous memory. Each byte is one read cycle followed by one
// write cycle; the read data arrives on MemDataOut during the write cycle and
// is forwarded straight to MemDataIn.
//
// Handshake: START is a request that is accepted only while the engine is
// IDLE (ignored otherwise); SRC/DST/LEN are captured on the accepted edge.
// DONE is a single-cycle completion strobe (state FIN) with no back-pressure.
// HOLD is a level request to yield the bus; it takes effect only at a byte
// boundary, so a read is never separated from its write.
module mem_dma_copy #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [AW-1:0] LEN,
  input  logic          HOLD,
  output logic [AW-1:0] MemAddress,
  output logic          MemWE,
  output logic [DW-1:0] MemDataIn,
  input  logic [DW-1:0] MemDataOut,
  output logic          BUSY,
  output logic          DONE,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_PAUSE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_src_ptr;
  logic [AW-1:0] r_dst_ptr;
  logic [AW-1:0] r_count;
  logic          w_last_byte;

  assign w_last_byte = (r_count == AW'(1));
  assign o_dbg_state = r_state;

  // State register; reset forces IDLE so bus outputs drop asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Transfer pointers and byte counter: captured on accepted START,
  // advanced once per completed write. Pointers wrap naturally at 2^AW.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_count   <= '0;
    end else if (r_state == S_IDLE && START) begin
      r_src_ptr <= SRC;
      r_dst_ptr <= DST;
      r_count   <= LEN;
    end else if (r_state == S_WRITE) begin
      r_src_ptr <= r_src_ptr + AW'(1);
      r_dst_ptr <= r_dst_ptr + AW'(1);
      r_count   <= r_count - AW'(1);
    end
  end

  // Next-state logic and bus/status decode, purely from the current state.
  always_comb begin
    w_next     = r_state;
    MemAddress = '0;
    MemWE      = 1'b0;
    MemDataIn  = '0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          if (LEN == '0) begin
            w_next = S_FIN;
          end else if (HOLD) begin
            w_next = S_PAUSE;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_READ: begin
        MemAddress = r_src_ptr;
        BUSY       = 1'b1;
        w_next     = S_WRITE;
      end
      S_WRITE: begin
        MemAddress = r_dst_ptr;
        MemWE      = 1'b1;
        MemDataIn  = MemDataOut;
        BUSY       = 1'b1;
        if (w_last_byte) begin
          w_next = S_FIN;
        end else if (HOLD) begin
          w_next = S_PAUSE;
        end else begin
          w_next = S_READ;
        end
      end
      S_PAUSE: begin
        BUSY = 1'b1;
        if (!HOLD) begin
          w_next = S_READ;
        end
      end
      S_FIN: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma_copy.sv
// tb_mem_dma_copy: drives mem_dma_copy against a behavioural 64K x 8 memory.
// A reference model performs each copy byte-by-byte on a shadow array and
// queues the expected (read address, write address, write data) triples; a
// monitor pops them whenever the engine presents a write cycle.
module tb_mem_dma_copy;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [15:0] SRC;
  logic [15:0] DST;
  logic [15:0] LEN;
  logic        HOLD;
  logic [15:0] MemAddress;
  logic        MemWE;
  logic [7:0]  MemDataIn;
  logic [7:0]  mem_dout;
  logic        BUSY;
  logic        DONE;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int exp_dones = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  mem[0:65535];
  logic [7:0]  ref_mem[0:65535];
  logic        init_req;
  logic        poke_en;
  logic [15:0] poke_addr;
  logic [7:0]  poke_data;
  logic [15:0] prev_addr;

  mem_dma_copy #(.AW(16), .DW(8)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .SRC        (SRC),
    .DST        (DST),
    .LEN        (LEN),
    .HOLD       (HOLD),
    .MemAddress (MemAddress),
    .MemWE      (MemWE),
    .MemDataIn  (MemDataIn),
    .MemDataOut (mem_dout),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  function automatic logic [7:0] base_byte(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8] * 8'd37;
    return a[7:0] ^ hi ^ 8'h5A;
  endfunction

  // Synchronous memory: write on WE, otherwise load read data at the edge.
  always @(posedge CLK) begin
    if (init_req) begin
      for (int a = 0; a < 65536; a++) mem[a] <= base_byte(16'(a));
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (MemWE) begin
      mem[MemAddress] <= MemDataIn;
    end else begin
      mem_dout <= mem[MemAddress];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin : mon
    logic [39:0] e;
    if (RESET_N === 1'b1) begin
      if (MemWE === 1'b1) begin
        chk("busy_in_write", 64'(BUSY), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   MemAddress, MemDataIn);
        end else begin
          e = exp_q.pop_front();
          chk("bus_rd_wr_data", 64'({prev_addr, MemAddress, MemDataIn}), 64'(e));
        end
        wr_seen++;
      end
      if (DONE === 1'b1) begin
        chk("done_bus_quiet", 64'({BUSY, MemWE}), 64'd0);
        done_seen++;
      end
    end
    prev_addr = MemAddress;
  end

  // ---------------- reference model ----------------
  task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    logic [15:0] s;
    logic [15:0] d;
    logic [7:0]  b;
    for (int i = 0; i < int'(len); i++) begin
      s = src + 16'(i);
      d = dst + 16'(i);
      b = ref_mem[s];
      ref_mem[d] = b;
      exp_q.push_back({s, d, b});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    @(posedge CLK); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge CLK); #1;
    poke_en = 1'b0;
  endtask

  // Issue one transfer; HOLD is random (rnd_hold) or high in cycles hs..he.
  // Cycle 1 is the cycle after the START edge.
  task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                          input bit rnd_hold, input int hs, input int he, input int exp_done,
                          input bit chk_hold, input bit dbl_start);
    int  c;
    int  budget;
    bit  busy_ok;
    bit  seen_done;
    model_copy(src, dst, len);
    exp_dones++;
    budget = 6 * int'(len) + 40;
    @(posedge CLK); #1;
    SRC = src; DST = dst; LEN = len; START = 1'b1;
    HOLD = rnd_hold ? ($urandom_range(0, 2) == 0) : 1'b0;
    @(posedge CLK); #1;
    START = dbl_start;
    if (dbl_start) begin
      SRC = src + 16'h0100; DST = dst ^ 16'h0800; LEN = len + 16'd2;
    end
    c = 1; busy_ok = 1'b1; seen_done = 1'b0;
    while (c <= budget) begin
      HOLD = rnd_hold ? ($urandom_range(0, 2) == 0) : (c >= hs && c <= he);
      if (c == 2) begin
        START = 1'b0; SRC = 16'($urandom); DST = 16'($urandom); LEN = 16'($urandom);
      end
      @(negedge CLK);
      if (chk_hold && c == 4) chk("hold_write_kept", 64'(MemWE), 64'd1);
      if (chk_hold && c >= 5 && c <= 8) chk("hold_pause_bus", 64'({MemWE, BUSY}), 64'd1);
      if (DONE === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      @(posedge CLK); #1;
      c++;
    end
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no DONE within %0d cycles expected DONE", budget);
    end else if (exp_done > 0) begin
      chk("done_cycle", 64'(c), 64'(exp_done));
    end
    chk("busy_until_done", 64'(busy_ok), 64'd1);
    HOLD = 1'b0; START = 1'b0;
    @(posedge CLK); #1;
    chk("idle_after_done", 64'({BUSY, DONE, MemWE}), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Reset asserted in the middle of the second write cycle of a transfer.
  task automatic reset_mid(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    int target;
    int d0;
    int n;
    model_copy(src, dst, 16'd1);
    target = wr_seen + 1;
    @(posedge CLK); #1;
    SRC = src; DST = dst; LEN = len; START = 1'b1; HOLD = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    n = 0;
    while (wr_seen < target && n < 20) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL rst_first_write_timeout: got %0d writes expected %0d", wr_seen, target);
    end
    @(posedge CLK); #1;
    chk("rst_in_write", 64'(MemWE), 64'd1);
    RESET_N = 1'b0;
    #1;
    chk("rst_async_drop", 64'({MemWE, BUSY, DONE, MemAddress}), 64'd0);
    d0 = done_seen;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_no_done", 64'(done_seen), 64'(d0));
    chk("rst_idle", 64'({BUSY, MemWE}), 64'd0);
    chk("rst_queue", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus / final report ----------------
  initial begin
    int          wr0;
    int          mism;
    logic [15:0] s;
    logic [15:0] d;
    logic [15:0] l;
    bit          rh;
    RESET_N = 1'b0; START = 1'b0; SRC = '0; DST = '0; LEN = '0; HOLD = 1'b0;
    init_req = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0; prev_addr = '0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = base_byte(16'(a));
    @(posedge CLK); #1;
    init_req = 1'b0;
    chk("reset_outputs", 64'({MemWE, MemAddress, MemDataIn, BUSY, DONE}), 64'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // basic copy
    poke(16'h0037, 8'hDD); poke(16'h0038, 8'h11); poke(16'h0039, 8'h22);
    run_copy(16'h0037, 16'h0200, 16'd3, 1'b0, 0, 0, 7, 1'b0, 1'b0);
    chk("basic_data", 64'({mem[16'h0200], mem[16'h0201], mem[16'h0202]}), 64'h00DD1122);

    // zero length
    wr0 = wr_seen;
    run_copy(16'h1234, 16'h4000, 16'd0, 1'b0, 0, 0, 1, 1'b0, 1'b0);
    chk("zero_len_no_write", 64'(wr_seen), 64'(wr0));

    // address wrap
    poke(16'hFFFF, 8'hAA); poke(16'h0000, 8'hA2);
    run_copy(16'hFFFF, 16'h0300, 16'd2, 1'b0, 0, 0, 5, 1'b0, 1'b0);
    chk("wrap_data", 64'({mem[16'h0300], mem[16'h0301]}), 64'h0000AAA2);

    // HOLD during the second read for 5 cycles: 4 pause cycles, DONE 9 -> 13
    run_copy(16'h0500, 16'h0600, 16'd4, 1'b0, 3, 7, 13, 1'b1, 1'b0);

    // second START while busy is ignored
    run_copy(16'h0700, 16'h0800, 16'd5, 1'b0, 0, 0, 11, 1'b0, 1'b1);

    // reset mid-transfer, then a fresh transfer
    reset_mid(16'h0900, 16'h0A00, 16'd5);
    run_copy(16'h0B00, 16'h0C00, 16'd3, 1'b0, 0, 0, 7, 1'b0, 1'b0);

    // randomized transfers, including overlap, wrap and random HOLD
    for (int t = 0; t < 30; t++) begin
      l = 16'($urandom_range(0, 12));
      s = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 16'(s + 16'($urandom_range(1, int'(l) + 1))) : 16'($urandom);
      rh = 1'($urandom_range(0, 1));
      run_copy(s, d, l, rh, 0, 0, rh ? -1 : 2 * int'(l) + 1, 1'b0, 1'b0);
    end

    @(posedge CLK); #1;
    mism = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk("final_memory", 64'(mism), 64'd0);
    chk("done_count", 64'(done_seen), 64'(exp_dones));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dma_copy.md
Name: mem_dma_copy

Overview:
- Bus initiator for the 64K x 8 synchronous memory: the side that drives Address/WE/DataIn and consumes DataOut.
- Copies a block of LEN bytes from SRC to DST, one byte at a time, as a read cycle followed by a write cycle.
- Used to stage program/data images in memory without CPU involvement. External logic muxes the memory port between CPU and this block using BUSY.

Parameters:
- AW, 16, address width (memory is 2^AW bytes).
- DW, 8, data width.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  start request, sampled in IDLE only.
- SRC  in  AW  source base address, captured on accepted START.
- DST  in  AW  destination base address, captured on accepted START.
- LEN  in  AW  byte count, captured on accepted START; 0 is legal.
- HOLD  in  1  bus yield request; engine pauses at next byte boundary.
- MemAddress  out  AW  address to memory.
- MemWE  out  1  write enable to memory.
- MemDataIn  out  DW  write data to memory.
- MemDataOut  in  DW  memory read data; valid the cycle after a read cycle.
- BUSY  out  1  high while the engine owns or is paused on the bus (states READ, WRITE, PAUSE).
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Memory contract:
  - A cycle with WE=0 at address A loads DataOut with mem[A] at the closing edge.
  - A cycle with WE=1 writes DataIn at the closing edge; DataOut is unchanged.
- Registers: state, src_ptr, dst_ptr, count (AW bits). All reset asynchronously to IDLE / 0.
- Reset values: MemWE=0, MemAddress=0, MemDataIn=0, BUSY=0, DONE=0.
- Output decode is combinational from state:
  - READ: MemAddress=src_ptr, MemWE=0.
  - WRITE: MemAddress=dst_ptr, MemWE=1, MemDataIn=MemDataOut.
  - All other states: MemAddress=0, MemWE=0, MemDataIn=0.
- DONE=1 only in state FIN.
- IDLE, START=1: capture SRC/DST/LEN.
  - LEN=0 -> FIN.
  - Else HOLD=1 -> PAUSE.
  - Else -> READ.
- IDLE, START=0: stay in IDLE.
- READ: always -> WRITE next cycle. HOLD is ignored; a read is never split from its write.
- WRITE: src_ptr+1, dst_ptr+1, count-1. Pointers wrap modulo 2^AW (0xFFFF+1 = 0x0000).
  - count was 1 -> FIN.
  - Else HOLD=1 -> PAUSE.
  - Else -> READ.
- PAUSE: bus released (MemWE=0). Stay while HOLD=1; HOLD=0 -> READ.
- FIN: one cycle, then IDLE. BUSY=0 in FIN.
- Throughput: 2 cycles per byte with no HOLD. First READ is the cycle after the START edge.
- With LEN=N and no HOLD, DONE is high in cycle 2N+1 after the START edge.
- START while not IDLE is ignored; SRC/DST/LEN changes after capture have no effect.
- Overlapping ranges: strictly forward byte copy. If DST is in (SRC, SRC+LEN), earlier bytes propagate forward, as per byte-sequential semantics.
- RESET_N low mid-transfer: MemWE drops immediately (asynchronously). The partial copy is abandoned and no DONE is issued.
- LEN=0x0000 is a no-op, never a 65536-byte copy.

Test Plan:
- Basic copy: mem[0x0037..0x0039]=DD,11,22; START SRC=0x0037 DST=0x0200 LEN=3.
  - Required: bus sequence R37,W200,R38,W201,R39,W202 on consecutive cycles.
  - Required: mem[0x0200..0x0202]=DD,11,22, DONE pulse in cycle 7, BUSY high cycles 1-6.
- Zero length: START LEN=0 -> DONE in cycle 1, MemWE never asserted, BUSY stays 0.
- Wrap: SRC=0xFFFF DST=0x0300 LEN=2, mem[FFFF]=AA, mem[0000]=A2.
  - Required: reads at FFFF then 0000; mem[0300]=AA, mem[0301]=A2.
- HOLD mid-transfer: LEN=4, assert HOLD during the second READ for 5 cycles.
  - Required: second WRITE still occurs next cycle, then PAUSE with MemWE=0 for the HOLD duration.
  - Required: resumes with the third READ; data correct; DONE delayed by exactly the PAUSE length.
- START ignored while busy: second START with different SRC in the cycle after the first START -> only the first transfer executes.
- Reset mid-operation: RESET_N low during a WRITE cycle.
  - Required: MemWE=0 immediately, state IDLE, no DONE.
  - Required: a new START after release copies correctly from fresh SRC/DST.
